// File: rtl/axis_decimate_pkg.sv
// -----------------------------------------------------------------------------
// axis_decimate_pkg
// Shared types, width helpers and the sign-extension function for the
// axis_decimate sample-rate reducer.
//   out_width(w, r)   : output width holding the full r-sample sum of w-bit data
//   phase_width(r)    : phase counter width (1 bit when r = 1)
//   sext(x, w)        : sign-extend the low w bits of x to MAX_W bits
//   phase_t           : phase counter type for the default ratio
// Optional feature macro (used by axis_decimate): AXIS_DECIMATE_AVG_EN
// -----------------------------------------------------------------------------
package axis_decimate_pkg;

    // Widest intermediate used by sext(); callers size-cast the result down.
    localparam int MAX_W = 64;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_R     = 100;

    function automatic int out_width(input int width, input int r);
        return width + $clog2(r);
    endfunction

    function automatic int phase_width(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

    localparam int DEF_OUT_WIDTH = out_width(DEF_WIDTH, DEF_R);

    // Phase counter type for the default ratio; parameterised instances
    // derive their own counter width from phase_width().
    typedef logic [phase_width(DEF_R)-1:0] phase_t;

    // Shift the sign bit to the top, then arithmetic-shift back down.
    function automatic logic [MAX_W-1:0] sext(input logic [MAX_W-1:0] x,
                                              input int width);
        logic signed [MAX_W-1:0] t;
        t = $signed(x << (MAX_W - width));
        return t >>> (MAX_W - width);
    endfunction

endpackage

// File: rtl/axis_decimate_if.sv
// -----------------------------------------------------------------------------
// axis_decimate_if
// Minimal AXI-Stream bundle (tdata/tvalid/tready) of width DW.
//   master : drives tdata, tvalid; samples tready
//   slave  : samples tdata, tvalid; drives tready
// -----------------------------------------------------------------------------
interface axis_decimate_if #(
    parameter int DW = 16
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_out_reg.sv
// -----------------------------------------------------------------------------
// axis_out_reg
// One-entry AXI-Stream output holding register.
//   aclk, arst : clock, asynchronous active-high reset
//   load       : capture load_data and raise valid (wins over a drain)
//   load_data  : data to capture
//   ready      : downstream tready
//   valid      : downstream tvalid
//   data       : downstream tdata, stable while valid && !ready
//   full       : entry occupied (same as valid; used by upstream ready logic)
// The producer only asserts load when the entry is empty or draining this
// cycle, so a load never overwrites an unconsumed result.
// -----------------------------------------------------------------------------
module axis_out_reg #(
    parameter int W = 16
) (
    input  logic         aclk,
    input  logic         arst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         full
);
    logic         valid_reg, valid_next;
    logic [W-1:0] data_reg, data_next;

    always_comb begin
        valid_next = valid_reg;
        data_next  = data_reg;
        if (load) begin
            valid_next = 1'b1;
            data_next  = load_data;
        end else if (valid_reg && ready) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else begin
            valid_reg <= valid_next;
            data_reg  <= data_next;
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;
    assign full  = valid_reg;
endmodule

// File: rtl/axis_decimate.sv
// -----------------------------------------------------------------------------
// axis_decimate
// Decimating AXI-Stream stage: emits one sample per R accepted inputs.
//   aclk        : clock (rising edge)
//   arst        : asynchronous active-high reset
//   s_axis_data : WIDTH-bit signed input stream (slave)
//   m_axis_data : OUT_WIDTH-bit output stream (master), fully back-pressured
// Build option: define AXIS_DECIMATE_AVG_EN to output the boxcar sum of each
// group of R inputs; otherwise the output is the sign-extended last sample of
// each group.
// -----------------------------------------------------------------------------
module axis_decimate
    import axis_decimate_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int R         = 100,
    parameter int OUT_WIDTH = out_width(WIDTH, R)
) (
    input  logic                  aclk,
    input  logic                  arst,
    axis_decimate_if.slave        s_axis_data,
    axis_decimate_if.master       m_axis_data
);
    localparam int PW = phase_width(R);
    typedef logic [PW-1:0] phase_cnt_t;
    localparam phase_cnt_t PHASE_LAST = phase_cnt_t'(R - 1);

    phase_cnt_t           phase_reg, phase_next;
    logic                 in_fire;
    logic                 group_done;
    logic                 out_full;
    logic                 out_valid;
    logic [OUT_WIDTH-1:0] out_data;
    logic [OUT_WIDTH-1:0] sample_ext;
    logic [OUT_WIDTH-1:0] load_data;

    assign sample_ext = OUT_WIDTH'(sext(MAX_W'(s_axis_data.tdata), WIDTH));

    // Only the group-closing sample needs the output slot, so stall just there.
    assign s_axis_data.tready = !((phase_reg == PHASE_LAST) && out_full && !m_axis_data.tready);
    assign in_fire    = s_axis_data.tvalid && s_axis_data.tready;
    assign group_done = in_fire && (phase_reg == PHASE_LAST);

    always_comb begin
        phase_next = phase_reg;
        if (in_fire) begin
            phase_next = (phase_reg == PHASE_LAST) ? '0 : phase_reg + phase_cnt_t'(1);
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            phase_reg <= '0;
        end else begin
            phase_reg <= phase_next;
        end
    end

`ifdef AXIS_DECIMATE_AVG_EN
    logic [OUT_WIDTH-1:0] acc_reg, acc_next;
    logic [OUT_WIDTH-1:0] group_sum;

    // Phase 0 restarts the sum, so no explicit clear is needed between groups.
    assign group_sum = (phase_reg == '0) ? sample_ext : acc_reg + sample_ext;

    always_comb begin
        acc_next = acc_reg;
        if (in_fire) begin
            acc_next = group_sum;
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

    assign load_data = group_sum;
`else
    assign load_data = sample_ext;
`endif

    axis_out_reg #(
        .W (OUT_WIDTH)
    ) u_out_reg (
        .aclk      (aclk),
        .arst      (arst),
        .load      (group_done),
        .load_data (load_data),
        .ready     (m_axis_data.tready),
        .valid     (out_valid),
        .data      (out_data),
        .full      (out_full)
    );

    assign m_axis_data.tvalid = out_valid;
    assign m_axis_data.tdata  = out_data;
endmodule

// File: tb/tb_axis_decimate.sv
// -----------------------------------------------------------------------------
// tb_axis_decimate
// Directed bench for axis_decimate: WIDTH = 8 with R = 4 and R = 1 instances.
// Expected values follow the AXIS_DECIMATE_AVG_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_axis_decimate;

    logic aclk = 1'b0;
    logic arst = 1'b1;

    always #5 aclk = ~aclk;

    axis_decimate_if #(.DW(8))  s4 ();
    axis_decimate_if #(.DW(10)) m4 ();
    axis_decimate_if #(.DW(8))  s1 ();
    axis_decimate_if #(.DW(8))  m1 ();

    axis_decimate #(.WIDTH(8), .R(4)) dut4 (
        .aclk        (aclk),
        .arst        (arst),
        .s_axis_data (s4),
        .m_axis_data (m4)
    );

    axis_decimate #(.WIDTH(8), .R(1)) dut1 (
        .aclk        (aclk),
        .arst        (arst),
        .s_axis_data (s1),
        .m_axis_data (m1)
    );

`ifdef AXIS_DECIMATE_AVG_EN
    localparam logic [31:0] E_G1  = 32'd10;
    localparam logic [31:0] E_G2  = 32'd26;
    localparam logic [31:0] E_NEG = 32'h200;
    localparam logic [31:0] E_POS = 32'd508;
    localparam logic [31:0] E_RST = 32'd16;
`else
    localparam logic [31:0] E_G1  = 32'd4;
    localparam logic [31:0] E_G2  = 32'd8;
    localparam logic [31:0] E_NEG = 32'h380;
    localparam logic [31:0] E_POS = 32'h07F;
    localparam logic [31:0] E_RST = 32'd4;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Offer one sample to the R=4 instance; returns 1 ns after the accepting edge.
    task automatic send4(input logic [7:0] d);
        int waitc;
        waitc = 0;
        s4.tdata  = d;
        s4.tvalid = 1'b1;
        while (!s4.tready && waitc < 50) begin
            @(posedge aclk);
            #1;
            waitc++;
        end
        if (waitc >= 50) check_eq("send4_timeout", 32'(s4.tready), 32'd1);
        @(posedge aclk);
        #1;
        s4.tvalid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        logic [7:0] seq [8];
        logic [7:0] expq [$];
        logic [7:0] v;
        int idx;
        int outs;
        int cyc;
        bit accepted;

        for (int i = 0; i < 8; i++) seq[i] = 8'(i + 1);

        s4.tdata = '0; s4.tvalid = 1'b0; m4.tready = 1'b1;
        s1.tdata = '0; s1.tvalid = 1'b0; m1.tready = 1'b0;

        // Reset state
        #1;
        check_eq("rst_m_tvalid", 32'(m4.tvalid), 32'd0);
        check_eq("rst_m_tdata",  32'(m4.tdata),  32'd0);
        check_eq("rst_s_tready", 32'(s4.tready), 32'd1);
        repeat (3) @(posedge aclk);
        #1;
        arst = 1'b0;

        // Two groups, downstream always ready
        for (int i = 0; i < 8; i++) begin
            send4(seq[i]);
            if (i == 3) begin
                check_eq("g1_valid", 32'(m4.tvalid), 32'd1);
                check_eq("g1_data",  32'(m4.tdata),  E_G1);
            end else if (i == 7) begin
                check_eq("g2_valid", 32'(m4.tvalid), 32'd1);
                check_eq("g2_data",  32'(m4.tdata),  E_G2);
            end else begin
                check_eq($sformatf("partial_valid_%0d", i), 32'(m4.tvalid), 32'd0);
            end
        end
        idle_cycle();
        check_eq("g2_drained", 32'(m4.tvalid), 32'd0);

        // Extreme values
        for (int i = 0; i < 4; i++) send4(8'h80);
        check_eq("neg_valid", 32'(m4.tvalid), 32'd1);
        check_eq("neg_data",  32'(m4.tdata),  E_NEG);
        for (int i = 0; i < 4; i++) send4(8'h7F);
        check_eq("pos_valid", 32'(m4.tvalid), 32'd1);
        check_eq("pos_data",  32'(m4.tdata),  E_POS);
        idle_cycle();
        check_eq("pos_drained", 32'(m4.tvalid), 32'd0);

        // Back-pressure
        m4.tready = 1'b0;
        for (int i = 0; i < 4; i++) send4(seq[i]);
        check_eq("bp_g1_data", 32'(m4.tdata), E_G1);
        send4(seq[4]);
        check_eq("bp_ready_ph1", 32'(s4.tready), 32'd1);
        send4(seq[5]);
        check_eq("bp_ready_ph2", 32'(s4.tready), 32'd1);
        send4(seq[6]);
        check_eq("bp_ready_ph3", 32'(s4.tready), 32'd0);
        s4.tdata  = seq[7];
        s4.tvalid = 1'b1;
        idle_cycle();
        idle_cycle();
        check_eq("bp_stall_ready", 32'(s4.tready), 32'd0);
        check_eq("bp_hold_valid",  32'(m4.tvalid), 32'd1);
        check_eq("bp_hold_data",   32'(m4.tdata),  E_G1);
        m4.tready = 1'b1;
        #1;
        check_eq("bp_release_ready", 32'(s4.tready), 32'd1);
        @(posedge aclk);
        #1;
        s4.tvalid = 1'b0;
        check_eq("bp_reload_valid", 32'(m4.tvalid), 32'd1);
        check_eq("bp_reload_data",  32'(m4.tdata),  E_G2);
        idle_cycle();
        check_eq("bp_drained", 32'(m4.tvalid), 32'd0);

        // Reset mid-group discards the partial sum
        send4(8'd1);
        send4(8'd2);
        arst = 1'b1;
        #1;
        check_eq("mid_rst_valid", 32'(m4.tvalid), 32'd0);
        check_eq("mid_rst_ready", 32'(s4.tready), 32'd1);
        idle_cycle();
        idle_cycle();
        arst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send4(8'd4);
            check_eq($sformatf("post_rst_valid_%0d", i), 32'(m4.tvalid), 32'd0);
        end
        send4(8'd4);
        check_eq("post_rst_out_valid", 32'(m4.tvalid), 32'd1);
        check_eq("post_rst_out_data",  32'(m4.tdata),  E_RST);
        idle_cycle();

        // R = 1: register slice under random valid/ready
        idx = 0;
        outs = 0;
        cyc = 0;
        while ((idx < 40 || expq.size() != 0) && cyc < 2000) begin
            if (!s1.tvalid && idx < 40 && $urandom_range(0, 3) != 0) begin
                v = 8'(idx * 53 + 17);
                s1.tdata  = v;
                s1.tvalid = 1'b1;
            end
            m1.tready = ($urandom_range(0, 2) != 0);
            @(negedge aclk);
            if (m1.tvalid && m1.tready) begin
                check_eq($sformatf("r1_pending_%0d", outs), 32'(expq.size() != 0), 32'd1);
                if (expq.size() != 0) begin
                    check_eq($sformatf("r1_data_%0d", outs), 32'(m1.tdata), 32'(expq.pop_front()));
                end
                outs++;
            end
            accepted = s1.tvalid && s1.tready;
            if (accepted) begin
                expq.push_back(s1.tdata);
                idx++;
            end
            @(posedge aclk);
            #1;
            cyc++;
            if (accepted) s1.tvalid = 1'b0;
        end
        check_eq("r1_no_timeout", 32'(cyc < 2000), 32'd1);
        check_eq("r1_count", 32'(outs), 32'd40);
        m1.tready = 1'b1;
        idle_cycle();
        check_eq("r1_idle_valid", 32'(m1.tvalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_decimate.md
# axis_decimate

Decimating AXI-Stream sink/source for the delta-sigma DAC sample path. It accepts a high-rate signed sample stream and emits one output sample every R accepted inputs. This is the rate-reduction counterpart of the zero-order-hold interpolator, used on the loopback/monitor path to bring modulator-rate data back to the CIC input rate. Every output is either the boxcar sum of R inputs or the last input of each group (see Configuration), and it is delivered on a fully back-pressured AXI-Stream master port.

## Interface
- WIDTH, 16: input sample width, signed two's complement.
- R, 100: decimation ratio, ≥ 1.
- OUT_WIDTH, WIDTH + $clog2(R): output width; growth bits hold the full R-sample sum.
- aclk  input  1  sole clock; all logic is rising-edge.
- arst  input  1  reset, asynchronous assert, active-high; deassertion is synchronised externally to aclk.
- s_axis_data_tdata  input  WIDTH  input sample.
- s_axis_data_tvalid  input  1  input valid.
- s_axis_data_tready  output  1  input ready.
- m_axis_data_tdata  output  OUT_WIDTH  decimated sample.
- m_axis_data_tvalid  output  1  output valid.
- m_axis_data_tready  input  1  output ready.

## Operation
- Input handshake: s_axis_data_tvalid && s_axis_data_tready. Output handshake: m_axis_data_tvalid && m_axis_data_tready.
- Phase counter `phase` runs 0..R-1 and advances only on an input handshake. It wraps to 0 after R-1.
- Accumulator `acc` is OUT_WIDTH wide. Each input is sign-extended to OUT_WIDTH.
  - On an input handshake at phase 0: acc = sample.
  - At any other phase: acc = acc + sample.
  - No saturation is needed; OUT_WIDTH cannot overflow for R samples.
- Group completion is an input handshake at phase R-1. It loads the output register with acc + sample (or with the sample alone without the macro), sets m_axis_data_tvalid, and sets phase to 0.
- The output register holds its data stable while m_axis_data_tvalid = 1 and m_axis_data_tready = 0.
- On an output handshake with no simultaneous completion, m_axis_data_tvalid clears.
- Simultaneous output handshake and completion: the register reloads with the new group and m_axis_data_tvalid stays 1.
- s_axis_data_tready = !(phase == R-1 && m_axis_data_tvalid && !m_axis_data_tready). The block stalls only at the final sample of a group when the previous result is still unconsumed. s_axis_data_tready does not depend on s_axis_data_tvalid.
- R = 1: every input handshake completes a group, and the block behaves as a one-deep AXIS register slice.

## Timing
- Reset values: m_axis_data_tvalid = 0, m_axis_data_tdata = 0, phase = 0, acc = 0. During reset, s_axis_data_tready = 1 (combinational, phase = 0).
- Latency: m_axis_data_tvalid rises on the clock edge that captures the R-th input.
- Throughput: one input per cycle is sustained whenever the downstream accepts within R-1 cycles of m_axis_data_tvalid rising. At R = 1 this requires m_axis_data_tready held at 1.
- Reset mid-group discards the partial sum. The next accepted sample is phase 0.
- tdata on both ports is don't-care when the matching valid is 0. The bench checks data only on handshakes.

## Configuration
- Macro: AXIS_DECIMATE_AVG_EN.
- Defined: the output is the boxcar sum of the R inputs in each group. This is the boxcar average scaled by R, with no division.
- Undefined: the accumulator is removed, and the output is the sign-extended phase R-1 sample (pure decimation). Port widths are identical in both builds.

## Structure
- Package axis_decimate_pkg holds:
  - typedef phase_t (width $clog2(R) bits; 1 bit when R = 1).
  - localparam computing OUT_WIDTH.
  - function sext(), sign-extending WIDTH to OUT_WIDTH.
- One sub-module, axis_out_reg, is natural: a one-entry AXIS output holding register with load/handshake logic. It exposes a `full` signal used in the ready equation.
- Phase counter and accumulator stay in the top module.

## Test plan
- WIDTH = 8, R = 4, AVG_EN, m_axis_data_tready = 1. Inputs 1, 2, 3, 4, 5, 6, 7, 8 -> outputs 10 then 26 (OUT_WIDTH = 10), each valid one cycle after the 4th and 8th input.
- Same input sequence without the macro -> outputs 4 then 8, sign-extended.
- AVG_EN, four inputs of -128 -> output -512 (0x200 in 10 bits); four inputs of 127 -> output 508.
- Back-pressure: hold m_axis_data_tready = 0 after the first output.
  - s_axis_data_tready drops exactly when phase = 3.
  - The held output remains 10.
  - Releasing m_axis_data_tready -> 10 handshakes, then 26 is loaded on the same edge the 8th input is accepted.
- Assert arst after 2 of 4 inputs, then feed 4, 4, 4, 4 -> output 16. No output appears from the partial group, and m_axis_data_tvalid = 0 during reset.
- R = 1, random valid/ready toggling -> output stream equals the input stream (sign-extended), with no loss and no duplication.
